// File: rtl/add8_seq_arbiter.sv
// add8_seq_arbiter
//   Shares a single 8-bit ripple adder (Add8) between two requesters and
//   performs NBYTES-wide additions through it one byte per cycle. The carry
//   between bytes is held in a register.
//
// Optional feature macro: ADD8_SEQ_SUB_EN
//   Defined:   reqN_op = 1 selects A - B. Each B byte is inverted and the
//              initial carry is 1.
//   Undefined: reqN_op is ignored and every operation is A + B.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid / reqN_ready    request handshake for requester N (0 or 1)
//   reqN_a, reqN_b             operands, W = 8*NBYTES bits
//   reqN_op                    0 = add, 1 = subtract (only with ADD8_SEQ_SUB_EN)
//   rsp_valid / rsp_ready      response handshake
//   rsp_id                     requester that owns the result
//   rsp_sum, rsp_cout          result and final carry out
//   busy                       high while calculating or holding a response

// Add8: plain 8-bit ripple-carry adder
//   i_a, i_b   operand bytes
//   i_cin      carry in
//   o_sum      sum byte
//   o_cout     carry out of bit 7
module Add8 (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_sum,
  output logic       o_cout
);

  logic w_carry;

  // Ripple the carry bit by bit. A single variable is used for the running
  // carry so that no combinational feedback appears between processes.
  always_comb begin
    w_carry = i_cin;
    o_sum   = '0;
    for (int k = 0; k < 8; k++) begin
      o_sum[k] = i_a[k] ^ i_b[k] ^ w_carry;
      w_carry  = (i_a[k] & i_b[k]) | (w_carry & (i_a[k] ^ i_b[k]));
    end
    o_cout = w_carry;
  end

endmodule

module add8_seq_arbiter #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [8*NBYTES-1:0] req0_a,
  input  logic [8*NBYTES-1:0] req0_b,
  input  logic                req0_op,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [8*NBYTES-1:0] req1_a,
  input  logic [8*NBYTES-1:0] req1_b,
  input  logic                req1_op,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [8*NBYTES-1:0] rsp_sum,
  output logic                rsp_cout,
  output logic                busy
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic            r_ptr;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [IDXW-1:0] r_byteIdx;
  logic            r_carry;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_id;

  logic            w_grantId;
  logic            w_anyValid;
  logic            w_handshake;
  logic [W-1:0]    w_selA;
  logic [W-1:0]    w_selB;
  logic            w_selOp;
  logic [7:0]      w_bByte;
  logic [7:0]      w_sumByte;
  logic            w_coutByte;

  // With both requesters valid the priority pointer decides. Otherwise the
  // single valid requester wins. With neither valid the grant is a don't-care,
  // because the ready outputs also require w_anyValid.
  always_comb begin
    w_anyValid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) w_grantId = r_ptr;
    else                          w_grantId = req1_valid;
  end

  assign w_handshake = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign w_selA      = w_grantId ? req1_a : req0_a;
  assign w_selB      = w_grantId ? req1_b : req0_b;

`ifdef ADD8_SEQ_SUB_EN
  logic r_op;

  assign w_selOp = w_grantId ? req1_op : req0_op;
  assign w_bByte = r_op ? ~r_b[7:0] : r_b[7:0];

  // The op bit is held only to steer the B inversion during CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_op <= 1'b0;
    else if (w_handshake) r_op <= w_selOp;
  end
`else
  logic w_unusedOp;

  assign w_selOp    = 1'b0;
  assign w_bByte    = r_b[7:0];
  assign w_unusedOp = req0_op ^ req1_op;
`endif

  // The operand registers shift right by one byte per CALC cycle, so the
  // current byte is always the low byte.
  Add8 u_add8 (
    .i_a    (r_a[7:0]),
    .i_b    (w_bByte),
    .i_cin  (r_carry),
    .o_sum  (w_sumByte),
    .o_cout (w_coutByte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_handshake) w_nextState = CALC;
      CALC:    if (r_byteIdx == LAST_IDX) w_nextState = RESP;
      RESP:    if (rsp_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // The ready outputs are gated by rst_n so that they drop as soon as reset
  // is asserted, not at the next clock edge.
  always_comb begin
    rsp_valid  = (r_state == RESP);
    busy       = (r_state != IDLE);
    req0_ready = (r_state == IDLE) && rst_n && w_anyValid && !w_grantId;
    req1_ready = (r_state == IDLE) && rst_n && w_anyValid &&  w_grantId;
  end

  // A handshake latches the request and advances the pointer past the winner.
  // Each CALC cycle writes one result byte. The final carry is captured only
  // on the last byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_byteIdx <= '0;
      r_carry   <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_id      <= 1'b0;
    end else if (w_handshake) begin
      r_a       <= w_selA;
      r_b       <= w_selB;
      r_byteIdx <= '0;
      r_carry   <= w_selOp;
      r_id      <= w_grantId;
      r_ptr     <= ~w_grantId;
    end else if (r_state == CALC) begin
      r_a                         <= r_a >> 8;
      r_b                         <= r_b >> 8;
      r_sum[{r_byteIdx, 3'b000} +: 8] <= w_sumByte;
      r_carry                     <= w_coutByte;
      r_byteIdx                   <= r_byteIdx + 1'b1;
      if (r_byteIdx == LAST_IDX) r_cout <= w_coutByte;
    end
  end

  assign rsp_sum  = r_sum;
  assign rsp_cout = r_cout;
  assign rsp_id   = r_id;

endmodule

// File: tb/tb_add8_seq_arbiter.sv
// tb_add8_seq_arbiter
//   Scoreboard bench for add8_seq_arbiter with NBYTES = 4. Accepted requests
//   push an expected result from a wide-arithmetic reference model, and a
//   monitor compares every response cycle against the front of the queue.
//   Define ADD8_SEQ_SUB_EN for both the bench and the RTL to exercise subtract.
module tb_add8_seq_arbiter;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_op;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_op;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
  logic [W-1:0] rsp_sum;

  typedef struct {
    logic         id;
    logic [W-1:0] sum;
    logic         cout;
    logic         op;
    int           hsCyc;
  } exp_t;

  exp_t scoreQ[$];
  int   nChecks   = 0;
  int   nFails    = 0;
  int   cyc       = 0;
  logic modelPtr  = 1'b0;
  logic randReady = 1'b0;

  always #5 clk = ~clk;

  add8_seq_arbiter #(.NBYTES(NBYTES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .busy       (busy)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    nChecks++;
    nFails++;
    $display("[TB] FAIL %s", name);
  endtask

  // Reference model: the whole-word sum at W+1 bits. The top bit is the carry.
  function automatic exp_t refModel(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic op, input int c);
    exp_t       e;
    logic [W:0] full;
    full = {1'b0, a} + {1'b0, b};
`ifdef ADD8_SEQ_SUB_EN
    if (op) full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
`endif
    e.id    = id;
    e.sum   = full[W-1:0];
    e.cout  = full[W];
    e.op    = op;
    e.hsCyc = c;
    return e;
  endfunction

  // The caller enters just after a rising edge. The task returns just after
  // the edge that completed the handshake.
  task automatic applyStimulus(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    int waitCyc = 0;
    bit done    = 0;
    if (id == 0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
    else         begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
    while (!done) begin
      @(negedge clk);
      if ((id == 0) ? req0_ready : req1_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end else if (++waitCyc > 200) begin
        failNow("handshake_timeout");
        done = 1;
      end
    end
    if (id == 0) req0_valid = 1'b0;
    else         req1_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (scoreQ.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (scoreQ.size() != 0) failNow("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_sum", rsp_sum, 0);
    checkOutput("rst_rsp_cout", rsp_cout, 0);
    checkOutput("rst_rsp_id", rsp_id, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_req0_ready", req0_ready, 0);
    checkOutput("rst_req1_ready", req1_ready, 0);
    scoreQ.delete();
    modelPtr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: checks grants against the round-robin model, records accepted
  // requests, and compares every response cycle with the front of the queue.
  initial begin
    logic expG;
    logic prevValid;
    exp_t e;
    prevValid = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      checkOutput("ready_exclusive", {63'd0, req0_ready & req1_ready}, 0);
      if (req0_ready || req1_ready) begin
        expG = (req0_valid && req1_valid) ? modelPtr : req1_valid;
        checkOutput("grant_id", req1_ready, expG);
        if (expG) scoreQ.push_back(refModel(1'b1, req1_a, req1_b, req1_op, cyc));
        else      scoreQ.push_back(refModel(1'b0, req0_a, req0_b, req0_op, cyc));
        modelPtr = ~expG;
      end
      if (rsp_valid) begin
        checkOutput("ready_low_in_resp", {req0_ready, req1_ready}, 0);
        if (scoreQ.size() == 0) begin
          failNow("unexpected_response");
        end else begin
          e = scoreQ[0];
          checkOutput("rsp_sum", rsp_sum, e.sum);
          checkOutput("rsp_cout", rsp_cout, e.cout);
          checkOutput("rsp_id", rsp_id, e.id);
          if (!prevValid) checkOutput("rsp_latency", cyc - e.hsCyc, NBYTES + 1);
          if (rsp_ready) void'(scoreQ.pop_front());
        end
      end
      prevValid = rsp_valid;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (randReady) rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    req0_valid = 0; req0_a = '0; req0_b = '0; req0_op = 0;
    req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = 0;
    rsp_ready  = 1'b1;
    rst_n      = 1'b1;
    @(posedge clk);
    #1;
    applyReset();

    // Directed sums: single-byte carry, and a carry through all four bytes.
    applyStimulus(0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
    applyStimulus(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    waitDrain();

    // Both requesters always valid after reset: grants must alternate from 0.
    applyReset();
    fork
      begin
        applyStimulus(0, 32'h1234_5678, 32'h1111_1111, 1'b0);
        applyStimulus(0, 32'h8000_0000, 32'h8000_0000, 1'b0);
      end
      begin
        applyStimulus(1, 32'hDEAD_BEEF, 32'h0102_0304, 1'b0);
        applyStimulus(1, 32'h00FF_00FF, 32'h0001_0001, 1'b0);
      end
    join
    waitDrain();

    // Response stalled for three cycles, then accepted.
    rsp_ready = 1'b0;
    applyStimulus(1, 32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b0);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    if (!rsp_valid) failNow("rsp_valid_timeout");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("idle_after_accept", {rsp_valid, busy}, 0);
    @(posedge clk);
    #1;

    // Reset in the second CALC cycle aborts the request.
    applyStimulus(0, 32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
    @(posedge clk);
    #1;
    applyReset();
    applyStimulus(1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    waitDrain();

    // op = 1: subtract only when the feature is compiled in.
    applyStimulus(0, 32'h0000_0005, 32'h0000_0007, 1'b1);
    waitDrain();

    // Random traffic from both requesters with random response back-pressure.
    randReady = 1'b1;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          applyStimulus(0, (i % 5 == 0) ? 32'hFFFF_FFFF : W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
        end
      end
      begin
        for (int j = 0; j < 12; j++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          applyStimulus(1, W'($urandom), (j % 4 == 0) ? 32'h0000_0001 : W'($urandom), 1'($urandom_range(0, 1)));
        end
      end
    join
    randReady = 1'b0;
    @(posedge clk);
    #2;
    rsp_ready = 1'b1;
    waitDrain();

    checkOutput("queue_empty", scoreQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
